// File: rtl/bus_protocol_initiator.sv
// bus_protocol_initiator: single-outstanding requester on the req/rnw/addressAck/writeAck/readAck bus,
// turning local commands into one bus transaction each and returning a one-cycle response.
module bus_protocol_initiator #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_cmdValid,
  output logic              o_cmdReady,
  input  logic              i_cmdReadWrite_n,
  input  logic [AWIDTH-1:0] i_cmdAddr,
  input  logic [DWIDTH-1:0] i_cmdWdata,
  output logic              o_rspValid,
  output logic              o_rspReadWrite_n,
  output logic [DWIDTH-1:0] o_rspRdata,
  output logic              o_rspError,
  output logic              o_req,
  output logic              o_readWrite_n,
  output logic [AWIDTH-1:0] o_addr,
  output logic [DWIDTH-1:0] o_wdata,
  input  logic              i_addressAck,
  input  logic              i_writeAck,
  input  logic              i_readAck,
  input  logic [DWIDTH-1:0] i_rdata,
  output logic              o_protocolError
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt;
  logic w_accept, w_match, w_mis, w_done, w_to, w_perr;
  assign o_cmdReady = r_state == IDLE;
  // The captured direction selects which data ack is legal for the transaction in flight.
  always_comb begin
    w_accept = i_cmdValid && r_state == IDLE;
    w_match = o_readWrite_n ? i_readAck : i_writeAck;
    w_mis = o_readWrite_n ? i_writeAck : i_readAck;
    w_done = (r_state == ADDR && i_addressAck && w_match) || (r_state == DATA && w_match);
    w_to = TIMEOUT > 0 && r_state != IDLE && !w_done && r_cnt == TO_LAST;
    w_perr = (r_state == IDLE && (i_addressAck || i_writeAck || i_readAck)) ||
             (r_state != IDLE && w_mis) || (r_state == ADDR && w_match && !i_addressAck);
    w_state_nx = (w_done || w_to) ? IDLE :
                 w_accept ? ADDR :
                 (r_state == ADDR && i_addressAck) ? DATA : r_state;
  end
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      o_req <= 1'b0;
      o_readWrite_n <= 1'b0;
      o_addr <= '0;
      o_wdata <= '0;
      o_rspValid <= 1'b0;
      o_rspReadWrite_n <= 1'b0;
      o_rspRdata <= '0;
      o_rspError <= 1'b0;
      o_protocolError <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      o_req <= w_state_nx == ADDR;
      o_rspValid <= w_done || w_to;
      o_rspError <= w_to;
      o_rspRdata <= (w_done && o_readWrite_n) ? i_rdata : '0;
      o_protocolError <= o_protocolError || w_perr;
      if (w_done || w_to) o_rspReadWrite_n <= o_readWrite_n;
      if (w_accept) begin
        o_readWrite_n <= i_cmdReadWrite_n;
        o_addr <= i_cmdAddr;
        o_wdata <= i_cmdWdata;
        r_cnt <= '0;
      end else if (r_state != IDLE && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bus_protocol_initiator.sv
// tb_bus_protocol_initiator: directed checks of the bus initiator; u_dut uses the default
// timeout, u_dut_to uses TIMEOUT=4 for the timeout and completion-priority cases.
module tb_bus_protocol_initiator;
  logic clk = 1'b0, rst_n = 1'b0;
  logic sel = 1'b0, cv = 1'b0, rw = 1'b0, aa = 1'b0, wa = 1'b0, ra = 1'b0;
  logic [7:0] addr = '0, wd = '0, rd = '0;
  logic m_cv, m_aa, m_wa, m_ra, t_cv, t_aa, t_wa, t_ra;
  logic m_rdy, m_rsp, m_rsp_rnw, m_rsp_err, m_req, m_rnw, m_perr;
  logic [7:0] m_rsp_rd, m_addr, m_wdata;
  logic t_rdy, t_rsp, t_rsp_rnw, t_rsp_err, t_req, t_rnw, t_perr;
  logic [7:0] t_rsp_rd, t_addr, t_wdata;
  int n_checks = 0, n_errors = 0;
  int req_hi, rsp_cnt, rsp_at, rise;
  logic [7:0] rsp_rd;
  logic rsp_err, rsp_rnw, rsp_rdy, stable, prev;
  always #5 clk = ~clk;
  assign m_cv = cv && !sel;
  assign m_aa = aa && !sel;
  assign m_wa = wa && !sel;
  assign m_ra = ra && !sel;
  assign t_cv = cv && sel;
  assign t_aa = aa && sel;
  assign t_wa = wa && sel;
  assign t_ra = ra && sel;
  bus_protocol_initiator u_dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_cmdValid(m_cv), .o_cmdReady(m_rdy),
    .i_cmdReadWrite_n(rw), .i_cmdAddr(addr), .i_cmdWdata(wd),
    .o_rspValid(m_rsp), .o_rspReadWrite_n(m_rsp_rnw), .o_rspRdata(m_rsp_rd), .o_rspError(m_rsp_err),
    .o_req(m_req), .o_readWrite_n(m_rnw), .o_addr(m_addr), .o_wdata(m_wdata),
    .i_addressAck(m_aa), .i_writeAck(m_wa), .i_readAck(m_ra), .i_rdata(rd),
    .o_protocolError(m_perr)
  );
  bus_protocol_initiator #(.TIMEOUT(4)) u_dut_to (
    .i_clk(clk), .i_arst_n(rst_n), .i_cmdValid(t_cv), .o_cmdReady(t_rdy),
    .i_cmdReadWrite_n(rw), .i_cmdAddr(addr), .i_cmdWdata(wd),
    .o_rspValid(t_rsp), .o_rspReadWrite_n(t_rsp_rnw), .o_rspRdata(t_rsp_rd), .o_rspError(t_rsp_err),
    .o_req(t_req), .o_readWrite_n(t_rnw), .o_addr(t_addr), .o_wdata(t_wdata),
    .i_addressAck(t_aa), .i_writeAck(t_wa), .i_readAck(t_ra), .i_rdata(rd),
    .o_protocolError(t_perr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Issue one command to the selected DUT, then run n cycles with acks on the given cycle indices
  // (cycle 0 is the first cycle o_req is expected high; -1 means never).
  task automatic txn(input logic s, input logic rnw, input logic [7:0] a, input logic [7:0] d,
                     input int ca, input int cd, input int cs, input logic [7:0] rdv, input int n);
    logic q, r, rerr, rrnw, rrdy;
    logic [7:0] qa, qd, rrd;
    sel = s; rw = rnw; addr = a; wd = d; cv = 1'b1;
    tick();
    cv = 1'b0;
    req_hi = 0; rsp_cnt = 0; rsp_at = -1; stable = 1'b1;
    for (int c = 0; c < n; c++) begin
      q = s ? t_req : m_req;
      qa = s ? t_addr : m_addr;
      qd = s ? t_wdata : m_wdata;
      req_hi += int'(q);
      if (q && (qa !== a || qd !== d || (s ? t_rnw : m_rnw) !== rnw)) stable = 1'b0;
      aa = c == ca;
      wa = (c == cd && !rnw) || (c == cs && rnw);
      ra = (c == cd && rnw) || (c == cs && !rnw);
      rd = rdv;
      tick();
      r = s ? t_rsp : m_rsp;
      rrd = s ? t_rsp_rd : m_rsp_rd;
      rerr = s ? t_rsp_err : m_rsp_err;
      rrnw = s ? t_rsp_rnw : m_rsp_rnw;
      rrdy = s ? t_rdy : m_rdy;
      if (r) begin
        rsp_cnt++; rsp_at = c + 1; rsp_rd = rrd; rsp_err = rerr; rsp_rnw = rrnw; rsp_rdy = rrdy;
      end
    end
    aa = 1'b0; wa = 1'b0; ra = 1'b0;
  endtask
  initial begin
    tick();
    chk("rst_rdy", 32'(m_rdy), 1);
    chk("rst_req", 32'(m_req), 0);
    chk("rst_rsp", 32'(m_rsp), 0);
    chk("rst_perr", 32'(m_perr), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_rdy_to", 32'(t_rdy), 1);
    rst_n = 1'b1;
    tick();
    // write with addressAck two cycles into req and writeAck two cycles later
    txn(1'b0, 1'b0, 8'h3C, 8'hA5, 2, 4, -1, 8'h77, 8);
    chk("wr_req_cycles", 32'(req_hi), 3);
    chk("wr_stable", 32'(stable), 1);
    chk("wr_rsp_cnt", 32'(rsp_cnt), 1);
    chk("wr_rsp_at", 32'(rsp_at), 5);
    chk("wr_rsp_err", 32'(rsp_err), 0);
    chk("wr_rsp_rnw", 32'(rsp_rnw), 0);
    chk("wr_rsp_rd", 32'(rsp_rd), 0);
    chk("wr_rsp_rdy", 32'(rsp_rdy), 1);
    // read with addressAck and readAck together in the first req cycle
    txn(1'b0, 1'b1, 8'h10, 8'h00, 0, 0, -1, 8'h5A, 4);
    chk("rd_req_cycles", 32'(req_hi), 1);
    chk("rd_rsp_cnt", 32'(rsp_cnt), 1);
    chk("rd_rsp_at", 32'(rsp_at), 1);
    chk("rd_rsp_rd", 32'(rsp_rd), 8'h5A);
    chk("rd_rsp_rnw", 32'(rsp_rnw), 1);
    chk("rd_rsp_err", 32'(rsp_err), 0);
    chk("rd_idle_rd", 32'(m_rsp_rd), 0);
    // back-to-back: read command held on cmdValid while the write is in flight
    sel = 1'b0; rw = 1'b0; addr = 8'h20; wd = 8'h11; cv = 1'b1;
    tick();
    rw = 1'b1; addr = 8'h21;
    prev = 1'b1; rise = -1; rsp_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      if (m_req && !prev && rise < 0) rise = c;
      prev = m_req;
      if (c == 3) begin
        chk("b2b_wr_rsp", 32'(m_rsp), 1);
        chk("b2b_rdy", 32'(m_rdy), 1);
        chk("b2b_wr_rnw", 32'(m_rsp_rnw), 0);
      end
      if (c == 4) begin
        cv = 1'b0;
        chk("b2b_rd_addr", 32'(m_addr), 8'h21);
      end
      aa = c == 1 || c == 5; wa = c == 2; ra = c == 5; rd = 8'hC3;
      tick();
      if (m_rsp) begin rsp_cnt++; rsp_rd = m_rsp_rd; end
    end
    aa = 1'b0; wa = 1'b0; ra = 1'b0;
    chk("b2b_rise", 32'(rise), 4);
    chk("b2b_rsp_cnt", 32'(rsp_cnt), 2);
    chk("b2b_rd_data", 32'(rsp_rd), 8'hC3);
    // TIMEOUT=4 with a silent responder
    txn(1'b1, 1'b1, 8'h44, 8'h00, -1, -1, -1, 8'hEE, 8);
    chk("to_req_cycles", 32'(req_hi), 4);
    chk("to_rsp_cnt", 32'(rsp_cnt), 1);
    chk("to_rsp_at", 32'(rsp_at), 4);
    chk("to_rsp_err", 32'(rsp_err), 1);
    chk("to_rsp_rd", 32'(rsp_rd), 0);
    chk("to_rsp_rdy", 32'(rsp_rdy), 1);
    // completion in the last allowed cycle beats the timeout
    txn(1'b1, 1'b1, 8'h45, 8'h00, 3, 3, -1, 8'h99, 6);
    chk("tp_rsp_at", 32'(rsp_at), 4);
    chk("tp_rsp_err", 32'(rsp_err), 0);
    chk("tp_rsp_rd", 32'(rsp_rd), 8'h99);
    chk("tp_perr", 32'(t_perr), 0);
    // protocol errors: stray readAck in IDLE, then readAck during a write's data phase
    chk("pe_clean", 32'(m_perr), 0);
    sel = 1'b0; ra = 1'b1;
    tick();
    ra = 1'b0;
    chk("pe_idle_set", 32'(m_perr), 1);
    chk("pe_idle_rdy", 32'(m_rdy), 1);
    chk("pe_idle_rsp", 32'(m_rsp), 0);
    txn(1'b0, 1'b0, 8'h55, 8'h66, 0, 4, 2, 8'h12, 7);
    chk("pe_wr_rsp_cnt", 32'(rsp_cnt), 1);
    chk("pe_wr_rsp_at", 32'(rsp_at), 5);
    chk("pe_wr_rsp_err", 32'(rsp_err), 0);
    chk("pe_sticky", 32'(m_perr), 1);
    // asynchronous reset while in the data phase
    sel = 1'b0; rw = 1'b0; addr = 8'h66; wd = 8'h77; cv = 1'b1;
    tick();
    cv = 1'b0;
    chk("ar_req", 32'(m_req), 1);
    aa = 1'b1;
    tick();
    aa = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("ar_req_low", 32'(m_req), 0);
    chk("ar_rsp_low", 32'(m_rsp), 0);
    chk("ar_rdy", 32'(m_rdy), 1);
    chk("ar_perr_clr", 32'(m_perr), 0);
    tick();
    rst_n = 1'b1;
    rsp_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      rsp_cnt += int'(m_rsp);
    end
    chk("ar_no_rsp", 32'(rsp_cnt), 0);
    chk("ar_rdy_after", 32'(m_rdy), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bus_protocol_initiator.md
Name: bus_protocol_initiator

Overview:
- Requester end of the req/rnw/addressAck/writeAck/readAck bus.
- Accepts single read/write commands from a local command port and drives one transaction on the bus.
- Waits for the address-phase and data-phase acknowledges, then returns a one-cycle response with read data or error status.
- Connects directly to the target-side tc_* bus of the transaction engine and is checked by the same bus protocol assertion set.

Parameters:
- AWIDTH, 8, address width.
- DWIDTH, 8, data width.
- TIMEOUT, 16, max bus cycles from req assertion to completion; 0 disables timeout.

Ports:
- i_clk  in  1  bus clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_cmdValid  in  1  local command valid.
- o_cmdReady  out  1  command accepted when i_cmdValid && o_cmdReady.
- i_cmdReadWrite_n  in  1  1=read, 0=write.
- i_cmdAddr  in  AWIDTH  command address.
- i_cmdWdata  in  DWIDTH  write data.
- o_rspValid  out  1  one-cycle response pulse.
- o_rspReadWrite_n  out  1  type of completed command.
- o_rspRdata  out  DWIDTH  read data (0 for writes/errors).
- o_rspError  out  1  qualified by o_rspValid; 1 = timeout.
- o_req  out  1  bus request.
- o_readWrite_n  out  1  bus direction.
- o_addr  out  AWIDTH  bus address.
- o_wdata  out  DWIDTH  bus write data.
- i_addressAck  in  1  address-phase ack pulse.
- i_writeAck  in  1  write data ack pulse.
- i_readAck  in  1  read data ack pulse.
- i_rdata  in  DWIDTH  read data, valid with i_readAck.
- o_protocolError  out  1  sticky; cleared only by reset.

Behaviour:
- Single clock, i_clk. i_arst_n is asynchronous and active-low, fully asynchronous assert; deassertion is externally synchronised.
- Reset: all outputs 0 except o_cmdReady=1; state IDLE; timeout counter 0.
- Reset mid-transaction forces o_req=0 immediately and discards the command with no response.
- FSM states: IDLE, ADDR, DATA. All bus outputs are registered.
- o_cmdReady = (state==IDLE). At most one transaction outstanding.
- IDLE: on handshake at cycle n, capture rnw/addr/wdata into o_readWrite_n/o_addr/o_wdata and set o_req=1 at n+1; go ADDR.
- ADDR: o_req, o_readWrite_n, o_addr and o_wdata are held stable until i_addressAck is sampled high.
  - On i_addressAck, o_req=0 next cycle.
  - If the matching data ack (i_writeAck for write, i_readAck for read) is also high that cycle, complete; otherwise go DATA.
- DATA: o_req=0; wait for the matching data ack, then complete.
- Completion on ack at cycle m:
  - State IDLE at m+1.
  - o_rspValid=1 at m+1 for exactly one cycle.
  - o_rspRdata = i_rdata sampled at m for reads, 0 for writes.
  - o_rspError=0.
  - o_cmdReady=1 at m+1, so a new command can be accepted at m+1 and o_req rises at m+2.
- Mismatched ack (i_readAck during a write, i_writeAck during a read), any ack in IDLE, or a data ack in ADDR without i_addressAck:
  - Ack is ignored.
  - o_protocolError set and stays set.
  - State is unchanged.
- Timeout (TIMEOUT>0):
  - Counter clears on command accept and increments each cycle in ADDR/DATA.
  - If completion has not occurred when count == TIMEOUT-1, the next cycle gives: o_req=0, state IDLE, o_rspValid=1, o_rspError=1, o_rspRdata=0.
  - Completion in that same cycle takes priority over timeout.
- Counter width is clog2(TIMEOUT+1), and it saturates and never wraps.
- While IDLE, bus address/data outputs hold their last values; o_rspRdata holds only during the valid cycle, otherwise 0.

Test Plan:
- Write addr 0x3C data 0xA5; responder gives addressAck at req+2 and writeAck at req+4 -> o_req high 3 cycles, o_addr=0x3C/o_wdata=0xA5 stable, one rspValid pulse with error=0, rnw=0.
- Read addr 0x10; addressAck and readAck in the same cycle with i_rdata=0x5A -> o_req drops next cycle, rspValid next cycle with rspRdata=0x5A.
- Back-to-back: write then read held on i_cmdValid -> second o_req rises exactly 2 cycles after the first data ack; no overlap of transactions.
- TIMEOUT=4, responder never acks -> o_req high 4 cycles, then rspValid with rspError=1, cmdReady=1 the same cycle.
- Stray readAck in IDLE, then readAck during a write's DATA state -> o_protocolError=1 sticky; write still completes only on writeAck.
- Assert i_arst_n low while in DATA -> o_req, o_rspValid=0 immediately, no response after release, o_cmdReady=1.
